// File: rtl/arbitro_conversor_bcd.sv
// -----------------------------------------------------------------------------
// arbitro_conversor_bcd
//
// Shares one external combinational binary-to-BCD converter between two
// requesters with a round-robin req/ack handshake. Each channel keeps its own
// 12-bit BCD result. A free-running scanner multiplexes the three digits of
// the selected channel onto a common-anode 7-segment display.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays lit (>= 1)
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req0/val0/ack0      channel 0 request, operand, one-cycle completion pulse
//   req1/val1/ack1      channel 1 request, operand, one-cycle completion pulse
//   conv_bin            registered operand, drives the converter bin_in
//   conv_cent/dez/uni   converter outputs (hundreds, tens, units)
//   bcd0, bcd1          stored results {centenas, dezenas, unidades}
//   disp_sel            display channel (0 -> bcd0, 1 -> bcd1)
//   an                  active-low one-hot anodes (bit0 units .. bit2 hundreds)
//   digit               BCD nibble for the segment decoder
//
// Build option:
//   BLANK_ZEROS_EN      when defined, leading zeros of hundreds/tens are blanked
// -----------------------------------------------------------------------------
module arbitro_conversor_bcd #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  val0,
  output logic        ack0,
  input  logic        req1,
  input  logic [7:0]  val1,
  output logic        ack1,
  output logic [7:0]  conv_bin,
  input  logic [3:0]  conv_cent,
  input  logic [3:0]  conv_dez,
  input  logic [3:0]  conv_uni,
  output logic [11:0] bcd0,
  output logic [11:0] bcd1,
  input  logic        disp_sel,
  output logic [2:0]  an,
  output logic [3:0]  digit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  state_t state, state_nxt;
  logic   grant;       // channel currently being served
  logic   last_grant;  // channel served most recently, for tie breaking
  logic   winner;
  logic   start;
  logic   capture;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone request wins; on a tie the channel not served last wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    winner = 1'b0;
    unique case ({req1, req0})
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state logic / output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req0 || req1) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;   // requests are ignored here
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start   = (state == S_IDLE) && (req0 || req1);
    capture = (state == S_LOAD);
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath: operand register -> external converter -> result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result registers are plain flops, not a memory array, and
      // must read as zero after reset, so they are reset explicitly.
      conv_bin   <= 8'h00;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      bcd0       <= 12'h000;
      bcd1       <= 12'h000;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (start) begin
        conv_bin   <= winner ? val1 : val0;
        grant      <= winner;
        last_grant <= winner;
      end
      if (capture) begin
        if (grant) begin
          bcd1 <= {conv_cent, conv_dez, conv_uni};
          ack1 <= 1'b1;
        end else begin
          bcd0 <= {conv_cent, conv_dez, conv_uni};
          ack0 <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [11:0]      sel_bcd;
  logic [2:0]       an_nxt;
  logic [3:0]       digit_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    sel_bcd   = disp_sel ? bcd1 : bcd0;
    an_nxt    = 3'b111;
    digit_nxt = 4'h0;
    unique case (idx)
      2'd0: begin an_nxt = 3'b110; digit_nxt = sel_bcd[3:0];  end
      2'd1: begin an_nxt = 3'b101; digit_nxt = sel_bcd[7:4];  end
      2'd2: begin an_nxt = 3'b011; digit_nxt = sel_bcd[11:8]; end
      default: begin an_nxt = 3'b111; digit_nxt = 4'h0; end
    endcase
`ifdef BLANK_ZEROS_EN
    // Blank leading zeros; the units digit always stays lit.
    if (sel_bcd[11:8] == 4'h0) begin
      an_nxt[2] = 1'b1;
      if (sel_bcd[7:4] == 4'h0) an_nxt[1] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= 3'b111;
      digit <= 4'h0;
    end else begin
      an    <= an_nxt;
      digit <= digit_nxt;
    end
  end

endmodule

// File: tb/tb_arbitro_conversor_bcd.sv
// -----------------------------------------------------------------------------
// tb_arbitro_conversor_bcd
//
// Directed bench for arbitro_conversor_bcd with a behavioural binary-to-BCD
// converter on the conv_* path. Inputs are driven and outputs sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_arbitro_conversor_bcd;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  val0, val1;
  logic        ack0, ack1;
  logic [7:0]  conv_bin;
  logic [3:0]  conv_cent, conv_dez, conv_uni;
  logic [11:0] bcd0, bcd1;
  logic        disp_sel;
  logic [2:0]  an;
  logic [3:0]  digit;

  int n_tests = 0;
  int n_fail  = 0;

  arbitro_conversor_bcd #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .val0      (val0),
    .ack0      (ack0),
    .req1      (req1),
    .val1      (val1),
    .ack1      (ack1),
    .conv_bin  (conv_bin),
    .conv_cent (conv_cent),
    .conv_dez  (conv_dez),
    .conv_uni  (conv_uni),
    .bcd0      (bcd0),
    .bcd1      (bcd1),
    .disp_sel  (disp_sel),
    .an        (an),
    .digit     (digit)
  );

  always #5 clk = ~clk;

  // External converter
  always_comb begin
    conv_cent = 4'(int'(conv_bin) / 100);
    conv_dez  = 4'((int'(conv_bin) / 10) % 10);
    conv_uni  = 4'(int'(conv_bin) % 10);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; the two acks must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_conv_bin", 32'(conv_bin), 32'h00);
    check("rst_bcd0", 32'(bcd0), 32'h000);
    check("rst_bcd1", 32'(bcd1), 32'h000);
    check("rst_an", 32'(an), 32'b111);
    check("rst_digit", 32'(digit), 32'h0);
    rst = 1'b0;
  endtask

  logic [2:0] exp_an [3];
  logic [3:0] exp_dg [3];
  logic [2:0] prev_an;
  logic       found;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    val0 = 8'd0; val1 = 8'd0; disp_sel = 1'b0;

    // --- Single request on channel 0 ---
    do_reset();
    req0 = 1'b1; val0 = 8'd255;
    tick();
    check("single_conv_bin", 32'(conv_bin), 32'hFF);
    check("single_ack0_early", 32'(ack0), 32'd0);
    check("first_lit_an", 32'(an), 32'b110);
    val0 = 8'd1;                       // ignored after sampling
    tick();
    check("single_ack0", 32'(ack0), 32'd1);
    check("single_bcd0", 32'(bcd0), 32'h255);
    check("single_bcd1", 32'(bcd1), 32'h000);
    req0 = 1'b0;
    tick();
    check("single_ack0_low", 32'(ack0), 32'd0);
    check("single_bcd0_hold", 32'(bcd0), 32'h255);

    // --- Fairness: channel 0 was served last, so channel 1 wins the tie ---
    req0 = 1'b1; val0 = 8'd9;
    req1 = 1'b1; val1 = 8'd99;
    tick();
    check("rr_conv_bin1", 32'(conv_bin), 32'h63);
    tick();
    check("rr_ack1", 32'(ack1), 32'd1);
    check("rr_ack0_idle", 32'(ack0), 32'd0);
    check("rr_bcd1", 32'(bcd1), 32'h099);
    check("rr_bcd0_untouched", 32'(bcd0), 32'h255);
    req1 = 1'b0;
    tick();
    tick();
    check("rr_conv_bin0", 32'(conv_bin), 32'h09);
    tick();
    check("rr_ack0", 32'(ack0), 32'd1);
    check("rr_bcd0", 32'(bcd0), 32'h009);
    check("rr_bcd1_hold", 32'(bcd1), 32'h099);
    req0 = 1'b0;
    tick();

    // --- Tie after reset: channel 0 first, channel 1 three cycles later ---
    do_reset();
    req0 = 1'b1; val0 = 8'd0;
    req1 = 1'b1; val1 = 8'd128;
    tick();
    check("tie_conv_bin0", 32'(conv_bin), 32'h00);
    tick();
    check("tie_ack0", 32'(ack0), 32'd1);
    check("tie_ack1_idle", 32'(ack1), 32'd0);
    check("tie_bcd0", 32'(bcd0), 32'h000);
    req0 = 1'b0;
    tick();
    tick();
    check("tie_conv_bin1", 32'(conv_bin), 32'h80);
    tick();
    check("tie_ack1", 32'(ack1), 32'd1);
    check("tie_bcd1", 32'(bcd1), 32'h128);
    req1 = 1'b0;
    tick();
    check("tie_ack1_low", 32'(ack1), 32'd0);

    // --- Reset during LOAD discards the conversion ---
    req0 = 1'b1; val0 = 8'd77;
    tick();                            // now in LOAD
    check("abort_conv_bin", 32'(conv_bin), 32'h4D);
    rst = 1'b1;
    tick();
    check("abort_ack0", 32'(ack0), 32'd0);
    check("abort_bcd0", 32'(bcd0), 32'h000);
    rst = 1'b0;
    tick();
    check("retry_conv_bin", 32'(conv_bin), 32'h4D);
    tick();
    check("retry_ack0", 32'(ack0), 32'd1);
    check("retry_bcd0", 32'(bcd0), 32'h077);
    req0 = 1'b0;
    tick();

    // --- Held request: second conversion starts right after DONE ---
    req1 = 1'b1; val1 = 8'd200;
    tick();
    tick();
    check("held_ack1_a", 32'(ack1), 32'd1);
    check("held_bcd1_a", 32'(bcd1), 32'h200);
    tick();
    check("held_ack1_gap", 32'(ack1), 32'd0);
    tick();
    check("held_conv_bin", 32'(conv_bin), 32'hC8);
    tick();
    check("held_ack1_b", 32'(ack1), 32'd1);
    check("held_bcd1_b", 32'(bcd1), 32'h200);
    req1 = 1'b0;
    tick();

    // --- Display scan of bcd0 = 042 ---
    req0 = 1'b1; val0 = 8'd42;
    tick();
    tick();
    check("scan_bcd0", 32'(bcd0), 32'h042);
    req0 = 1'b0;
    disp_sel = 1'b0;
    exp_an[0] = 3'b110; exp_dg[0] = 4'd2;
    exp_an[1] = 3'b101; exp_dg[1] = 4'd4;
`ifdef BLANK_ZEROS_EN
    exp_an[2] = 3'b111; exp_dg[2] = 4'd0;
`else
    exp_an[2] = 3'b011; exp_dg[2] = 4'd0;
`endif
    found   = 1'b0;
    prev_an = an;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (an == 3'b110 && prev_an != 3'b110) found = 1'b1;
      prev_an = an;
    end
    check("scan_sync", 32'(found), 32'd1);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        check($sformatf("scan_an_p%0d_c%0d", p, c), 32'(an), 32'(exp_an[p]));
        check($sformatf("scan_dg_p%0d_c%0d", p, c), 32'(digit), 32'(exp_dg[p]));
        tick();
      end
    end
    // Channel switch shows on the next registered update (bcd1 = 200).
    check("scan_wrap_an", 32'(an), 32'b110);
    disp_sel = 1'b1;
    tick();
    check("scan_sel1_digit", 32'(digit), 32'd0);
    tick();
    tick();
    tick();
    check("scan_sel1_an", 32'(an), 32'b101);
    check("scan_sel1_tens", 32'(digit), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
